// File: rtl/cog_vidx.sv
// cog_vidx: waitvid-style video shifter with a 2-deep frame FIFO, pixel/frame counters and grouped pin drive
module cog_vidx #(
  parameter int PIX_W   = 32,
  parameter int COLOR_W = 128,
  parameter int GROUPS  = 4
) (
  input  logic                  clk_cog,
  input  logic                  res,
  input  logic                  tick,
  input  logic                  setvid,
  input  logic                  setscl,
  input  logic [31:0]           data,
  input  logic                  wv_valid,
  output logic                  wv_ready,
  input  logic [PIX_W-1:0]      pixel,
  input  logic [COLOR_W-1:0]    color,
  output logic [8*GROUPS-1:0]   pin_out,
  output logic                  underrun,
  output logic                  busy
);
  localparam int GW = $clog2(GROUPS);
  localparam int EW = PIX_W + COLOR_W;
  logic [31:0] vid_q, vid_d, scl_q, scl_d;
  logic [EW-1:0] fifo_q [2];
  logic [EW-1:0] fifo_d [2];
  logic [1:0] count_q, count_d, slot;
  logic [PIX_W-1:0] pixels_q, pixels_d, last_q, last_d, shifted;
  logic [COLOR_W-1:0] colors_q, colors_d, col_sh;
  logic [7:0] discrete_q, discrete_d, cnt_q, cnt_d, masked;
  logic [11:0] set_q, set_d;
  logic underrun_q, underrun_d;
  logic en, have, new_set, new_cnt, push, pop;
  logic [1:0] bsel;
  logic [3:0] idx;
  logic [GW-1:0] gsel;
  logic unused_ok;
  assign en = (vid_q[30:29] != 2'b00) && !res;
  assign bsel = vid_q[28:27];
  assign gsel = vid_q[8+GW:9];
  assign wv_ready = en && !count_q[1];
  assign busy = count_q != 2'd0;
  assign underrun = underrun_q;
  assign masked = discrete_q & vid_q[7:0];
  assign unused_ok = ^{vid_q[31], vid_q[26:9+GW], scl_q[31:20]};
  always_comb begin
    have = count_q != 2'd0;
    new_set = en && tick && set_q == 12'd1;
    new_cnt = en && tick && cnt_q == 8'd1;
    pop = new_set && have;
    push = wv_valid && wv_ready;
    idx = bsel == 2'd0 ? {3'b000, pixels_q[0]} : bsel == 2'd1 ? {2'b00, pixels_q[1:0]} : pixels_q[3:0];
    shifted = bsel == 2'd0 ? {pixels_q[PIX_W-1], pixels_q[PIX_W-1:1]} :
              bsel == 2'd1 ? {pixels_q[PIX_W-1 -: 2], pixels_q[PIX_W-1:2]} :
                             {pixels_q[PIX_W-1 -: 4], pixels_q[PIX_W-1:4]};
    // entries past the end of the table shift out to zero
    col_sh = colors_q >> {idx, 3'b000};
    vid_d = setvid ? data : vid_q;
    scl_d = setscl ? data : scl_q;
    fifo_d[0] = pop ? fifo_q[1] : fifo_q[0];
    fifo_d[1] = fifo_q[1];
    slot = count_q - 2'(pop);
    if (push && !slot[0]) fifo_d[0] = {pixel, color};
    if (push && slot[0]) fifo_d[1] = {pixel, color};
    count_d = en ? count_q + 2'(push) - 2'(pop) : 2'd0;
    // an empty FIFO at a boundary replays the last frame as it was loaded
    pixels_d = new_set ? (have ? fifo_q[0][EW-1 -: PIX_W] : last_q) : new_cnt ? shifted : pixels_q;
    last_d = pop ? fifo_q[0][EW-1 -: PIX_W] : last_q;
    colors_d = pop ? fifo_q[0][COLOR_W-1:0] : colors_q;
    set_d = !en ? 12'd1 : new_set ? scl_q[11:0] : tick ? set_q - 12'd1 : set_q;
    cnt_d = !en ? 8'd1 : (new_set || new_cnt) ? scl_q[19:12] : tick ? cnt_q - 8'd1 : cnt_q;
    discrete_d = (en && tick) ? col_sh[7:0] : discrete_q;
    underrun_d = (new_set && !have) || (underrun_q && !setvid);
  end
  for (genvar g = 0; g < GROUPS; g++) begin : g_pins
    assign pin_out[8*g +: 8] = (en && gsel == GW'(g)) ? masked : 8'h00;
  end
  always_ff @(posedge clk_cog) begin
    if (res) begin
      vid_q <= '0;
      scl_q <= '0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      count_q <= '0;
      pixels_q <= '0;
      last_q <= '0;
      colors_q <= '0;
      discrete_q <= '0;
      set_q <= 12'd1;
      cnt_q <= 8'd1;
      underrun_q <= 1'b0;
    end else begin
      vid_q <= vid_d;
      scl_q <= scl_d;
      fifo_q[0] <= fifo_d[0];
      fifo_q[1] <= fifo_d[1];
      count_q <= count_d;
      pixels_q <= pixels_d;
      last_q <= last_d;
      colors_q <= colors_d;
      discrete_q <= discrete_d;
      set_q <= set_d;
      cnt_q <= cnt_d;
      underrun_q <= underrun_d;
    end
  end
endmodule
